// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        CPL
    } arb_state_t;

    localparam int unsigned UART_MIN_LEN = 5;
    localparam int unsigned UART_MAX_LEN = 8;

    // Bit positions inside one requester's 7-bit frame configuration word
    localparam int unsigned CFG_W         = 7;
    localparam int unsigned CFG_STOP2_BIT = 6;
    localparam int unsigned CFG_PEN_BIT   = 5;
    localparam int unsigned CFG_PTYPE_BIT = 4;
    localparam int unsigned CFG_LEN_LSB   = 0;

    function automatic logic len_ok(input logic [3:0] len);
        return (len >= 4'(UART_MIN_LEN)) && (len <= 4'(UART_MAX_LEN));
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin grant: first set request after last_i, wrapping.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_idx_o,
    output logic               gnt_any_o
);

    int unsigned idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_i) + k) % NUM_REQ;
            if (!gnt_any_o && req_i[idx[IW-1:0]]) begin
                gnt_any_o             = 1'b1;
                gnt_o[idx[IW-1:0]]    = 1'b1;
                gnt_idx_o             = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Optional WAIT watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32,
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic                   tx_clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ*7-1:0]   req_cfg,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   cpl_valid,
    output logic [IW-1:0]          cpl_id,
    output logic                   cpl_err,
    output logic                   busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [3:0]             length,
    output logic                   parity_type,
    output logic                   parity_en,
    output logic                   stop2,
    input  logic                   tx_done,
    input  logic                   tx_err
);

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    cpl_id_q, cpl_id_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       len_q, len_d;
    logic             ptype_q, ptype_d;
    logic             pen_q, pen_d;
    logic             stop2_q, stop2_d;
    logic             err_q, err_d;
    logic             tx_start_q, tx_start_d;
    logic             cpl_valid_q, cpl_valid_d;
    logic             cpl_err_q, cpl_err_d;
    logic             busy_q, busy_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [CFG_W-1:0]   cfg_sel;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    assign cfg_sel = req_cfg[32'(gnt_idx) * CFG_W +: CFG_W];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cpl_id_d    = cpl_id_q;
        data_d      = data_q;
        len_d       = len_q;
        ptype_d     = ptype_q;
        pen_d       = pen_q;
        stop2_d     = stop2_q;
        err_d       = err_q;
        tx_start_d  = 1'b0;
        cpl_valid_d = 1'b0;
        cpl_err_d   = 1'b0;
        req_ready   = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    last_d    = gnt_idx;
                    cpl_id_d  = gnt_idx;
                    data_d    = req_data[{gnt_idx, 3'b000} +: 8];
                    // Rejected lengths leave the transmitter config untouched
                    if (len_ok(cfg_sel[CFG_LEN_LSB +: 4])) begin
                        len_d      = cfg_sel[CFG_LEN_LSB +: 4];
                        ptype_d    = cfg_sel[CFG_PTYPE_BIT];
                        pen_d      = cfg_sel[CFG_PEN_BIT];
                        stop2_d    = cfg_sel[CFG_STOP2_BIT];
                        tx_start_d = 1'b1;
                        state_d    = START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        err_d       = 1'b1;
                        cpl_valid_d = 1'b1;
                        cpl_err_d   = 1'b1;
                        state_d     = CPL;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                err_d = err_q | tx_err;
                if (tx_done) begin
                    cpl_valid_d = 1'b1;
                    cpl_err_d   = err_d;
                    state_d     = CPL;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d       = 1'b1;
                    cpl_valid_d = 1'b1;
                    cpl_err_d   = 1'b1;
                    state_d     = CPL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            CPL: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            cpl_id_q    <= '0;
            data_q      <= '0;
            len_q       <= 4'd8;
            ptype_q     <= 1'b0;
            pen_q       <= 1'b0;
            stop2_q     <= 1'b0;
            err_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cpl_id_q    <= cpl_id_d;
            data_q      <= data_d;
            len_q       <= len_d;
            ptype_q     <= ptype_d;
            pen_q       <= pen_d;
            stop2_q     <= stop2_d;
            err_q       <= err_d;
            tx_start_q  <= tx_start_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_err_q   <= cpl_err_d;
            busy_q      <= busy_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cpl_valid   = cpl_valid_q;
    assign cpl_id      = cpl_id_q;
    assign cpl_err     = cpl_err_q;
    assign busy        = busy_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = data_q;
    assign length      = len_q;
    assign parity_type = ptype_q;
    assign parity_en   = pen_q;
    assign stop2       = stop2_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: event-timeline model plus directed literal checks.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TMO = 32;
    localparam int BIG = 1 << 30;

    logic            tx_clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*8-1:0]  req_data = '0;
    logic [N*7-1:0]  req_cfg = '0;
    logic [N-1:0]    req_ready;
    logic            cpl_valid, cpl_err, busy, tx_start;
    logic [IW-1:0]   cpl_id;
    logic [7:0]      tx_data;
    logic [3:0]      length;
    logic            parity_type, parity_en, stop2;
    logic            tx_done = 1'b0;
    logic            tx_err = 1'b0;

    uart_tx_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .tx_clk(tx_clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_cfg(req_cfg), .req_ready(req_ready), .cpl_valid(cpl_valid), .cpl_id(cpl_id),
        .cpl_err(cpl_err), .busy(busy), .tx_start(tx_start), .tx_data(tx_data),
        .length(length), .parity_type(parity_type), .parity_en(parity_en), .stop2(stop2),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transmitter stand-in: tx_done done_delay cycles after tx_start, optional tx_err pulse
    bit auto_done = 1'b1;
    int done_delay = 4;
    int err_at = 0;
    initial begin
        forever begin
            @(negedge tx_clk);
            if (tx_start && auto_done) begin
                for (int k = 1; k <= done_delay; k++) begin
                    @(posedge tx_clk); #1;
                    tx_err  = (k == err_at);
                    tx_done = (k == done_delay);
                end
                @(posedge tx_clk); #1;
                tx_done = 1'b0;
                tx_err  = 1'b0;
            end
        end
    end

    // Model state: timeline of expected events
    bit           chk_en = 1'b0;
    int           m_last = N - 1;
    int           m_free = 0;
    int           m_start = -1;
    int           m_cpl = -1;
    bit           m_wait = 1'b0;
    bit           m_err = 1'b0;
    bit           m_cerr = 1'b0;
    int           m_cid = 0;
    logic [7:0]   m_data = '0;
    logic [6:0]   m_cfg = 7'h08;
    logic [6:0]   g_cfg;
    bit           e_busy, found;
    logic [N-1:0] e_ready;
    int           m_g, idx;

    int g_id[$], g_cyc[$], s_cyc[$], s_data[$], s_pen[$], d_cyc[$], c_id[$], c_err[$], c_cyc[$];
    int n_grant = 0, n_start = 0, n_cpl = 0;

    always @(negedge tx_clk) begin
        if (chk_en) begin
            e_busy  = (cyc < m_free);
            e_ready = '0;
            found   = 1'b0;
            m_g     = 0;
            if (!e_busy && rst_n) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        m_g   = idx;
                    end
                end
            end
            if (found) e_ready[m_g] = 1'b1;

            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("busy", busy, e_busy);
            chk("tx_start", tx_start, cyc == m_start);
            chk("cpl_valid", cpl_valid, cyc == m_cpl);
            if (cyc == m_cpl) begin
                chk("cpl_id", cpl_id, m_cid);
                chk("cpl_err", cpl_err, m_cerr);
            end
            chk("cfg", {stop2, parity_en, parity_type, length}, m_cfg);
            if (m_wait && cyc >= m_start) chk("tx_data", tx_data, m_data);

            if (|req_ready) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g_id.push_back(i);
                g_cyc.push_back(cyc);
                n_grant++;
            end
            if (tx_start) begin
                s_cyc.push_back(cyc); s_data.push_back(tx_data); s_pen.push_back(parity_en);
                n_start++;
            end
            if (tx_done) d_cyc.push_back(cyc);
            if (cpl_valid) begin
                c_id.push_back(cpl_id); c_err.push_back(cpl_err); c_cyc.push_back(cyc);
                n_cpl++;
            end

            if (found) begin
                m_last = m_g;
                m_cid  = m_g;
                g_cfg  = req_cfg[7*m_g +: 7];
                if (g_cfg[3:0] >= 5 && g_cfg[3:0] <= 8) begin
                    m_cfg   = g_cfg;
                    m_data  = req_data[8*m_g +: 8];
                    m_start = cyc + 1;
                    m_wait  = 1'b1;
                    m_err   = 1'b0;
                    m_free  = BIG;
                end else begin
                    m_cpl  = cyc + 1;
                    m_cerr = 1'b1;
                    m_free = cyc + 2;
                end
            end else if (m_wait && cyc > m_start) begin
                m_err = m_err | tx_err;
`ifdef UART_TX_ARB_TIMEOUT_EN
                if (!tx_done && cyc - m_start == TMO) begin
                    m_cpl = cyc + 1; m_cerr = 1'b1; m_wait = 1'b0; m_free = cyc + 2;
                end
`endif
                if (tx_done) begin
                    m_cpl = cyc + 1; m_cerr = m_err; m_wait = 1'b0; m_free = cyc + 2;
                end
            end

            if (!rst_n) begin
                m_last = N - 1; m_free = cyc + 1; m_start = -1; m_cpl = -1;
                m_wait = 1'b0; m_err = 1'b0; m_cfg = 7'h08;
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] d, input logic [6:0] c);
        req_data[8*i +: 8] = d;
        req_cfg[7*i +: 7]  = c;
    endtask

    task automatic wait_grant(input int n);
        int t = 0;
        while (n_grant < n && t < 200) begin @(negedge tx_clk); #2; t++; end
        if (n_grant < n) chk("grant_timeout", n_grant, n);
    endtask

    task automatic wait_cpl(input int n);
        int t = 0;
        while (n_cpl < n && t < 500) begin @(negedge tx_clk); #2; t++; end
        if (n_cpl < n) chk("cpl_timeout", n_cpl, n);
    endtask

    task automatic request(input logic [N-1:0] mask);
        int b = n_grant;
        @(posedge tx_clk); #1 req_valid = mask;
        wait_grant(b + 1);
        @(posedge tx_clk); #1 req_valid = '0;
    endtask

    task automatic reset_dut();
        @(posedge tx_clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1 rst_n = 1'b1;
    endtask

    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int exp_dat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int rej_id[4]  = '{2, 1, 3, 0};
    int rej_len[4] = '{3, 9, 4, 0};
    int gb, sb, cb;

    initial begin
        @(posedge tx_clk); #1 chk_en = 1'b1;
        @(posedge tx_clk); #1 rst_n = 1'b1;
        @(negedge tx_clk);
        chk("rst_length", length, 4'd8);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_cpl_valid", cpl_valid, 1'b0);

        // Single request from requester 0
        set_req(0, 8'hA5, 7'h38);
        done_delay = 4;
        request(4'b0001);
        wait_cpl(1);
        chk("t1_grant_id", g_id[0], 0);
        chk("t1_nstart", s_cyc.size(), 1);
        chk("t1_start_lat", s_cyc[0] - g_cyc[0], 1);
        chk("t1_tx_data", s_data[0], 8'hA5);
        chk("t1_parity_en", s_pen[0], 1);
        chk("t1_cpl_lat", c_cyc[0] - d_cyc[$], 1);
        chk("t1_cpl_id", c_id[0], 0);
        chk("t1_cpl_err", c_err[0], 0);

        // All four continuously requesting after reset
        reset_dut();
        set_req(0, 8'h11, 7'h08);
        set_req(1, 8'h22, 7'h17);
        set_req(2, 8'h33, 7'h66);
        set_req(3, 8'h44, 7'h45);
        done_delay = 5;
        gb = n_grant; sb = n_start; cb = n_cpl;
        @(posedge tx_clk); #1 req_valid = 4'b1111;
        wait_cpl(cb + 5);
        @(posedge tx_clk); #1 req_valid = '0;
        repeat (3) @(posedge tx_clk);
        chk("t2_ready_count", n_grant - gb, 5);
        for (int k = 0; k < 5; k++) begin
            chk("t2_order", g_id[gb + k], exp_ord[k]);
            chk("t2_data", s_data[sb + k], exp_dat[k]);
        end
        chk("t2_b2b_gap", g_cyc[gb + 1] - c_cyc[cb], 1);

        // Rejected lengths: no tx_start, immediate error completion
        for (int k = 0; k < 4; k++) begin
            set_req(rej_id[k], 8'h5A, 7'(rej_len[k]));
            sb = n_start; cb = n_cpl;
            request(4'b0001 << rej_id[k]);
            wait_cpl(cb + 1);
            chk("rej_no_start", n_start - sb, 0);
            chk("rej_id", c_id[cb], rej_id[k]);
            chk("rej_err", c_err[cb], 1);
            chk("rej_lat", c_cyc[cb] - g_cyc[$], 1);
        end

        // Reset while waiting on the transmitter
        auto_done = 1'b0;
        set_req(1, 8'hC3, 7'h28);
        sb = n_start;
        request(4'b0010);
        while (n_start == sb) begin @(negedge tx_clk); #2; end
        repeat (2) @(posedge tx_clk);
        cb = n_cpl;
        #1 rst_n = 1'b0;
        @(posedge tx_clk); #1 rst_n = 1'b1;
        @(negedge tx_clk);
        chk("t4_busy", busy, 1'b0);
        repeat (4) @(posedge tx_clk);
        chk("t4_no_cpl", n_cpl - cb, 0);
        auto_done = 1'b1;
        set_req(0, 8'h01, 7'h08);
        set_req(3, 8'h03, 7'h08);
        request(4'b1001);
        chk("t4_next_grant", g_id[$], 0);
        wait_cpl(cb + 1);

        // tx_err during WAIT, then a clean frame
        done_delay = 3; err_at = 1;
        set_req(2, 8'h77, 7'h07);
        cb = n_cpl;
        request(4'b0100);
        wait_cpl(cb + 1);
        chk("t5_err", c_err[cb], 1);
        err_at = 0;
        request(4'b0100);
        wait_cpl(cb + 2);
        chk("t5_clean", c_err[cb + 1], 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        auto_done = 1'b0;
        cb = n_cpl;
        request(4'b0001);
        wait_cpl(cb + 1);
        chk("tmo_lat", c_cyc[cb] - (s_cyc[$] + 1), TMO);
        chk("tmo_err", c_err[cb], 1);
        auto_done = 1'b1;
`endif

        repeat (3) @(posedge tx_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_REQ` byte requesters. It captures a requester's data byte and frame configuration, then drives the transmitter's `tx_start` and config inputs. It holds them stable until `tx_done` and returns a completion tagged with the requester id. It sits between the system-side byte sources and the single UART transmit datapath, in the `tx_clk` domain.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 32, watchdog limit in `tx_clk` cycles (used only with the config macro)

- `tx_clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_REQ  request pending, one bit per requester
- `req_data`  in  NUM_REQ*8  byte per requester; requester i at [8i+7:8i]
- `req_cfg`  in  NUM_REQ*7  per requester {stop2, parity_en, parity_type, length[3:0]} at [7i+6:7i]
- `req_ready`  out  NUM_REQ  one-cycle one-hot pulse: payload of that requester captured
- `cpl_valid`  out  1  one-cycle completion pulse
- `cpl_id`  out  $clog2(NUM_REQ)  requester id of the completion
- `cpl_err`  out  1  completion error flag
- `busy`  out  1  high whenever not in IDLE
- `tx_start`  out  1  start pulse to transmitter
- `tx_data`  out  8  byte to transmitter
- `length`, `parity_type`, `parity_en`, `stop2`  out  4/1/1/1  frame config to transmitter
- `tx_done`  in  1  transmitter frame-complete pulse
- `tx_err`  in  1  transmitter error

## Operation
- One clock, one reset. The reset is synchronous and active-low.
- On reset:
  - state = IDLE.
  - All outputs are 0, except `length` = 4'd8.
  - Round-robin pointer `last` = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, START, WAIT, CPL.
- IDLE:
  - If any `req_valid` is set, grant the first set bit searching from `last`+1 with wrap-around.
  - `req_ready[g]`=1 combinationally in the same cycle.
  - At that edge: capture `req_data[g]` and `req_cfg[g]` into the output registers, set `last`=g, latch `cpl_id`=g.
  - If the length is valid: next state START. If it is invalid: next state CPL with error flag set, and the frame is not sent.
  - With no request pending, stay in IDLE.
- Length check: valid lengths are 5..8 inclusive. Any other value is rejected. The transmitter config outputs keep their previous values.
- START:
  - `tx_start`=1 for exactly one cycle.
  - Next state WAIT.
- WAIT:
  - `tx_data` and the config outputs are held stable.
  - `tx_err` is ORed into the error flag every cycle.
  - On `tx_done`=1, next state CPL.
- CPL:
  - `cpl_valid`=1 for one cycle; `cpl_err` = error flag.
  - The error flag clears at the exit edge. Next state IDLE.
- A requester that drops `req_valid` before its grant is simply not served. `req_valid` is ignored outside IDLE.
- Simultaneous requests: only one grant per IDLE cycle. The pointer guarantees each waiting requester is served within NUM_REQ frames.
- Reset mid-frame: the arbiter returns to IDLE next edge and no completion is issued. The top level resets the transmitter in the same cycle.

## Timing
- Grant to `tx_start`: `req_ready` in cycle N, `tx_start` in cycle N+1.
- `tx_done` to completion: `tx_done` in cycle M, `cpl_valid` in cycle M+1.
- IDLE is re-entered in cycle M+2. The earliest next `req_ready` is in cycle M+2.
- Back-to-back frames therefore have a 3-cycle overhead beyond the transmitter frame (CPL, IDLE grant, START).
- Rejected-length request: `req_ready` in cycle N, `cpl_valid` with `cpl_err`=1 in cycle N+1, no `tx_start`.
- All outputs are registered except `req_ready`.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without `tx_done`, go to CPL with `cpl_err`=1.
  - The counter clears on entering START.
- Not defined:
  - No counter. WAIT waits indefinitely for `tx_done`.

## Structure
- Shared package `uart_pkg`:
  - State enum `arb_state_t`.
  - Constants `UART_MIN_LEN`=5 and `UART_MAX_LEN`=8.
  - The cfg field offsets: stop2 = bit 6, parity_en = bit 5, parity_type = bit 4, length = bits 3:0.
- Sub-module `uart_rr_arbiter`: combinational round-robin grant from `req_valid` and `last`. It outputs a one-hot grant and a binary index.

## Test plan
- Single request: `req_valid`=4'b0001, data 8'hA5, cfg {0,1,1,4'd8}.
  - Required: `req_ready[0]` pulse, then `tx_start` one cycle later with `tx_data`=8'hA5 and `parity_en`=1.
  - Then `cpl_valid` with `cpl_id`=0 and `cpl_err`=0 one cycle after `tx_done`.
- All four requesting continuously after reset:
  - Required grant order 0,1,2,3,0.
  - Exactly one `req_ready` per frame; config outputs stable from `tx_start` until `tx_done`.
- Requester 2 only, with length 4'd3:
  - Required: `req_ready[2]`, no `tx_start`, next-cycle `cpl_valid` with `cpl_id`=2 and `cpl_err`=1.
- `rst_n` low during WAIT:
  - Required: IDLE next edge, `busy`=0, no `cpl_valid`.
  - Next grant goes to requester 0.
- With the macro defined, TIMEOUT_CYCLES=32, `tx_done` held 0:
  - Required: `cpl_valid` with `cpl_err`=1 exactly 32 cycles after entering WAIT.
- `tx_err`=1 for one WAIT cycle, then `tx_done`:
  - Required: completion with `cpl_err`=1.
  - The following frame completes with `cpl_err`=0.
